// File: rtl/vram_pkg.sv
// Shared constants, command payload and FSM state encoding for the VRAM write engine.
package vram_pkg;

  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned COORD_W    = 8;
  localparam int unsigned BMP_BYTES  = 6144;
  localparam int unsigned ATTR_BYTES = 768;
  localparam int unsigned FILL_BYTES = BMP_BYTES + ATTR_BYTES;
  localparam int unsigned ROWS       = 192;

  localparam logic [ADDR_W-1:0] BMP_BASE  = 13'h0000;
  localparam logic [ADDR_W-1:0] ATTR_BASE = 13'h1800;

  typedef enum logic [1:0] {
    OP_SET  = 2'b00,
    OP_CLR  = 2'b01,
    OP_XOR  = 2'b10,
    OP_FILL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_ATTR,
    ST_FILL
  } state_e;

  typedef struct packed {
    op_e                op;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DATA_W-1:0]  color;
  } cmd_t;

  // Linear fill index -> VRAM address: bitmap bytes first, then attributes.
  function automatic logic [ADDR_W-1:0] fill_addr(input logic [ADDR_W-1:0] n);
    if (n < ADDR_W'(BMP_BYTES)) return BMP_BASE + n;
    return ATTR_BASE + (n - ADDR_W'(BMP_BYTES));
  endfunction

endpackage

// File: rtl/vram_plotter_if.sv
// Command handshake plus dedicated VRAM write-port signals of the plotter.
interface vram_plotter_if;
  import vram_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [COORD_W-1:0]  cmd_x;
  logic [COORD_W-1:0]  cmd_y;
  logic [DATA_W-1:0]   cmd_color;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;

  // Command source and VRAM side.
  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, mem_rdata,
    input  cmd_ready, mem_addr, mem_wdata, mem_we
  );

  // Plotter engine side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, mem_rdata,
    output cmd_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/vram_addr_gen.sv
// Pixel coordinate -> bitmap byte address, attribute cell address and pixel bit mask.
module vram_addr_gen
  import vram_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  bmp_addr_c,
  output logic [ADDR_W-1:0]  attr_addr_c,
  output logic [DATA_W-1:0]  mask_c
);

  assign bmp_addr_c  = BMP_BASE | {y, x[7:3]};
  assign attr_addr_c = ATTR_BASE | ADDR_W'({y[7:3], x[7:3]});
  // MSB of each bitmap byte is the leftmost pixel.
  assign mask_c      = 8'h80 >> x[2:0];

endmodule

// File: rtl/vram_plotter.sv
// VRAM write engine: single-pixel read-modify-write with attribute update, and screen fill.
module vram_plotter
  import vram_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  vram_plotter_if.slave  bus
);

  localparam logic [COORD_W-1:0] ROW_LIMIT = COORD_W'(ROWS);
  localparam logic [ADDR_W-1:0]  FILL_END  = ADDR_W'(FILL_BYTES);
  localparam logic [ADDR_W-1:0]  BMP_END   = ADDR_W'(BMP_BYTES);

  state_e              state, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [ADDR_W-1:0]   cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;

  logic [COORD_W-1:0]  gen_x, gen_y;
  logic [ADDR_W-1:0]   bmp_addr_c, attr_addr_c;
  logic [DATA_W-1:0]   mask_c;

  // Address generator sees the incoming command while idle, the held one while busy.
  assign gen_x = (state == ST_IDLE) ? bus.cmd_x : cmd_q.x;
  assign gen_y = (state == ST_IDLE) ? bus.cmd_y : cmd_q.y;

  vram_addr_gen u_addr_gen (
    .x           (gen_x),
    .y           (gen_y),
    .bmp_addr_c  (bmp_addr_c),
    .attr_addr_c (attr_addr_c),
    .mask_c      (mask_c)
  );

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_d;
      cmd_q   <= cmd_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state;
    cmd_d   = cmd_q;
    cnt_d   = cnt;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.op    = op_e'(bus.cmd_op);
          cmd_d.x     = bus.cmd_x;
          cmd_d.y     = bus.cmd_y;
          cmd_d.color = bus.cmd_color;
          if (op_e'(bus.cmd_op) == OP_FILL) begin
            state_d = ST_FILL;
            addr_d  = fill_addr('0);
            wdata_d = '0;
            we_d    = 1'b1;
            cnt_d   = ADDR_W'(1);
          end else if (bus.cmd_y >= ROW_LIMIT) begin
            // Off-screen pixel: one idle cycle through ATTR with no write.
            state_d = ST_ATTR;
          end else begin
            state_d = ST_RD;
            addr_d  = bmp_addr_c;
          end
        end
      end

      ST_RD:   state_d = ST_WAIT;

      ST_WAIT: begin
        state_d = ST_WR;
        addr_d  = bmp_addr_c;
        we_d    = 1'b1;
        case (cmd_q.op)
          OP_SET:  wdata_d = bus.mem_rdata | mask_c;
          OP_CLR:  wdata_d = bus.mem_rdata & ~mask_c;
          default: wdata_d = bus.mem_rdata ^ mask_c;
        endcase
      end

      ST_WR: begin
        if (cmd_q.op == OP_SET) begin
          state_d = ST_ATTR;
          addr_d  = attr_addr_c;
          wdata_d = cmd_q.color;
          we_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ATTR: state_d = ST_IDLE;

      ST_FILL: begin
        if (cnt == FILL_END) begin
          state_d = ST_IDLE;
        end else begin
          addr_d  = fill_addr(cnt);
          wdata_d = (cnt < BMP_END) ? '0 : cmd_q.color;
          we_d    = 1'b1;
          cnt_d   = cnt + ADDR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
